// File: rtl/serial_pattern_tx_pkg.sv
// Shared constants and helpers for the serial pattern transmitter.
// Holds the FSM state encoding, the len-decode rule and the default
// len port width used by blocks that drive this transmitter.
package serial_pattern_tx_pkg;

  // FSM state encoding; 2'b11 is unused and recovers to idle.
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_GAP   = 2'b10;

  // Default frame width and the matching width of the len field.
  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned LEN_W         = $clog2(DEFAULT_WIDTH) + 1;

  // Effective frame length: 0 encodes a full-width frame and any request
  // longer than the register saturates to the full width.
  function automatic int unsigned decode_len(input int unsigned len_val,
                                             input int unsigned width);
    if ((len_val == 0) || (len_val > width)) begin
      return width;
    end
    return len_val;
  endfunction

endpackage

// File: rtl/flip_flop_D.sv
// Single-bit D flip-flop with asynchronous active-low reset.
// Shared cell used for the state bits of the serial FSMs.
module flip_flop_D #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  // Capture d on every rising edge; reset forces the reset value at once.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RESET_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/tx_shift_reg.sv
// WIDTH-bit parallel-load, left-shift register for the serial transmitter.
// Load has priority over shift; shifting fills with zeros from the LSB.
// The MSB is the bit currently presented on the serial line.
module tx_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] shreg;

  // Load a new frame, or advance the current one by one bit toward the MSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Moore parallel-to-serial transmitter driving the single-bit line W.
// A word is accepted in IDLE on start, shifted out MSB-first one bit per
// clock, then the line idles for GAP_CYCLES cycles before the next word.
// All outputs decode registered state only; inputs never reach an output
// without passing through a flop.
module serial_pattern_tx #(
  parameter int   WIDTH      = 8,
  parameter int   GAP_CYCLES = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [WIDTH-1:0]       data_in,
  input  logic [$clog2(WIDTH):0] len,
  input  logic                   start,
  output logic                   ready,
  output logic                   W,
  output logic                   bit_valid,
  output logic                   done
);

  import serial_pattern_tx_pkg::*;

  // bitcnt holds "bits remaining after the one on the line": 0..WIDTH-1.
  localparam int CNT_W = $clog2(WIDTH);
  // gapcnt holds "gap cycles remaining after this one": 0..GAP_CYCLES-1.
  localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] bitcnt;
  logic [CNT_W-1:0] bitcnt_nxt;
  logic [GAP_W-1:0] gapcnt;
  logic [GAP_W-1:0] gapcnt_nxt;
  logic             done_q;
  logic             done_nxt;
  logic             sr_load;
  logic             sr_shift;
  logic             sr_msb;

  // State register built from the shared D flip-flop cell.
  for (genvar i = 0; i < 2; i++) begin : g_state_ff
    flip_flop_D #(
      .RESET_VAL (1'b0)
    ) u_state_ff (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (state_nxt[i]),
      .q       (state[i])
    );
  end

  // Frame data path; its MSB is the bit on the line while shifting.
  tx_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift_reg (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (sr_load),
    .shift   (sr_shift),
    .din     (data_in),
    .msb     (sr_msb)
  );

  // Next-state, counter and shift-register control decode.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_nxt  = state;
    bitcnt_nxt = bitcnt;
    gapcnt_nxt = gapcnt;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          sr_load    = 1'b1;
          bitcnt_nxt = CNT_W'(decode_len(32'(len), WIDTH) - 1);
          state_nxt  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_shift = 1'b1;
        if (bitcnt == '0) begin
          gapcnt_nxt = GAP_LOAD;
          state_nxt  = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
        end else begin
          bitcnt_nxt = bitcnt - 1'b1;
        end
      end
      ST_GAP: begin
        if (gapcnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          gapcnt_nxt = gapcnt - 1'b1;
        end
      end
      default: begin
        state_nxt  = ST_IDLE;
        bitcnt_nxt = '0;
        gapcnt_nxt = '0;
      end
    endcase
  end

  // done is registered: it is set for the cycle the last bit sits on W.
  assign done_nxt = (state_nxt == ST_SHIFT) && (bitcnt_nxt == '0);

  // Counter and done registers; reset discards any frame in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bitcnt <= '0;
      gapcnt <= '0;
      done_q <= 1'b0;
    end else begin
      bitcnt <= bitcnt_nxt;
      gapcnt <= gapcnt_nxt;
      done_q <= done_nxt;
    end
  end

  // Moore output decode from registered state only.
  assign ready     = (state == ST_IDLE);
  assign bit_valid = (state == ST_SHIFT);
  assign W         = bit_valid ? sr_msb : IDLE_LEVEL;
  assign done      = done_q & bit_valid;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Self-checking bench for serial_pattern_tx.
// dut uses WIDTH=8, GAP_CYCLES=1; dut0 uses GAP_CYCLES=0 for back-to-back.
module tb_serial_pattern_tx;

  import serial_pattern_tx_pkg::*;

  localparam int WIDTH = 8;
  localparam int GAP   = 1;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] data_in;
  logic [LEN_W-1:0] len;
  logic             start;
  logic             start0;
  logic             ready,  w,  bit_valid,  done;
  logic             ready0, w0, bit_valid0, done0;

  int checks = 0;
  int errors = 0;

  serial_pattern_tx #(
    .WIDTH      (WIDTH),
    .GAP_CYCLES (GAP),
    .IDLE_LEVEL (1'b0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_in   (data_in),
    .len       (len),
    .start     (start),
    .ready     (ready),
    .W         (w),
    .bit_valid (bit_valid),
    .done      (done)
  );

  serial_pattern_tx #(
    .WIDTH      (WIDTH),
    .GAP_CYCLES (0),
    .IDLE_LEVEL (1'b0)
  ) dut0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .data_in   (data_in),
    .len       (len),
    .start     (start0),
    .ready     (ready0),
    .W         (w0),
    .bit_valid (bit_valid0),
    .done      (done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare {W, bit_valid, done, ready} field by field.
  task automatic cmp4(input string tag, input logic [3:0] act, input logic [3:0] exp);
    check({tag, " W"},         32'(act[3]), 32'(exp[3]));
    check({tag, " bit_valid"}, 32'(act[2]), 32'(exp[2]));
    check({tag, " done"},      32'(act[1]), 32'(exp[1]));
    check({tag, " ready"},     32'(act[0]), 32'(exp[0]));
  endtask

  task automatic expect_dut(input string tag, input logic ew, input logic ev,
                            input logic ed, input logic er);
    cmp4(tag, {w, bit_valid, done, ready}, {ew, ev, ed, er});
  endtask

  // From the current negedge, check bits first..n-1, the gap, then ready.
  task automatic check_frame(input string tag, input logic [7:0] bits,
                             input int first, input int n);
    for (int i = first; i < n; i++) begin
      expect_dut($sformatf("%s bit%0d", tag, i + 1), bits[7-i], 1'b1, (i == n - 1), 1'b0);
      @(negedge clk);
    end
    for (int g = 0; g < GAP; g++) begin
      expect_dut($sformatf("%s gap%0d", tag, g), 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
    end
    expect_dut({tag, " ready"}, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [3:0] len;
    int         n;
    logic [7:0] bits;
  } vec_t;

  typedef struct packed {
    logic w;
    logic v;
    logic d;
    logic r;
  } exp_t;

  vec_t tbl[7];
  exp_t model_q[$];

  initial begin
    tbl[0] = '{data: 8'hB4, len: 4'd0,  n: 8, bits: 8'hB4};
    tbl[1] = '{data: 8'hA0, len: 4'd3,  n: 3, bits: 8'hA0};
    tbl[2] = '{data: 8'hA0, len: 4'd12, n: 8, bits: 8'hA0};
    tbl[3] = '{data: 8'hC3, len: 4'd1,  n: 1, bits: 8'hC3};
    tbl[4] = '{data: 8'h01, len: 4'd9,  n: 8, bits: 8'h01};
    tbl[5] = '{data: 8'h6F, len: 4'd8,  n: 8, bits: 8'h6F};
    tbl[6] = '{data: 8'h40, len: 4'd2,  n: 2, bits: 8'h40};

    reset_n = 1'b0;
    data_in = '0;
    len     = '0;
    start   = 1'b0;
    start0  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expect_dut("reset", 1'b0, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    expect_dut("post-reset idle", 1'b0, 1'b0, 1'b0, 1'b1);

    // Table-driven frames: full, short, clamped, single-bit.
    for (int t = 0; t < 7; t++) begin
      data_in = tbl[t].data;
      len     = tbl[t].len;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      check_frame($sformatf("vec%0d", t), tbl[t].bits, 0, tbl[t].n);
    end

    // Busy: start and new data during bit 2 must not disturb the frame.
    data_in = 8'hB4;
    len     = 4'd0;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    expect_dut("busy bit1", 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    expect_dut("busy bit2", 1'b0, 1'b1, 1'b0, 1'b0);
    data_in = 8'hFF;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    check_frame("busy", 8'hB4, 2, 8);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      expect_dut($sformatf("busy no-second%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Abort: asynchronous reset during bit 4 takes effect before any edge.
    data_in = 8'hB4;
    len     = 4'd0;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
    end
    expect_dut("abort bit4", 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    expect_dut("abort async", 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      expect_dut($sformatf("abort idle%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Back-to-back on the zero-gap instance: W=1,0,idle repeating.
    data_in = 8'h81;
    len     = 4'd2;
    start0  = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      cmp4($sformatf("b2b%0d bit1", r), {w0, bit_valid0, done0, ready0}, 4'b1100);
      @(negedge clk);
      cmp4($sformatf("b2b%0d bit2", r), {w0, bit_valid0, done0, ready0}, 4'b0110);
      @(negedge clk);
      cmp4($sformatf("b2b%0d idle", r), {w0, bit_valid0, done0, ready0}, 4'b0001);
    end
    start0 = 1'b0;

    // Randomized traffic against a frame-level model: an accepted word
    // becomes its frame bits followed by the gap; an empty queue is idle.
    model_q.delete();
    for (int c = 0; c < 400; c++) begin
      exp_t e;
      bit   idle_now;
      int   n;
      idle_now = (model_q.size() == 0);
      if (idle_now) begin
        e = '{w: 1'b0, v: 1'b0, d: 1'b0, r: 1'b1};
      end else begin
        e = model_q.pop_front();
      end
      expect_dut($sformatf("rnd%0d", c), e.w, e.v, e.d, e.r);
      start   = ($urandom_range(0, 2) == 0);
      data_in = 8'($urandom);
      len     = 4'($urandom_range(0, 15));
      if (idle_now && start) begin
        n = ((len == 0) || (len > WIDTH)) ? WIDTH : int'(len);
        for (int i = 0; i < n; i++) begin
          model_q.push_back('{w: data_in[WIDTH-1-i], v: 1'b1, d: (i == n - 1), r: 1'b0});
        end
        for (int g = 0; g < GAP; g++) begin
          model_q.push_back('{w: 1'b0, v: 1'b0, d: 1'b0, r: 1'b0});
        end
      end
      @(negedge clk);
    end
    start = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
